// File: rtl/sevenseg_capture_if.sv
// Bus between the multiplexed 7-segment pins and the capture logic.
// Master drives the pins; slave reconstructs the digits.
interface sevenseg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_done;
  logic        pattern_err;
  logic [1:0]  err_digit;

  modport master (
    output seg, an,
    input  digits, blank, frame_done, pattern_err, err_digit
  );

  modport slave (
    input  seg, an,
    output digits, blank, frame_done, pattern_err, err_digit
  );
endinterface

// File: rtl/sevenseg_capture.sv
// Snoops a multiplexed active-low 7-segment display and rebuilds the four BCD digits.
// Define HEX_DECODE_EN to also accept the A..F glyphs as legal codes.
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  sevenseg_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  typedef enum logic [1:0] {PAT_DIGIT, PAT_BLANK, PAT_ILLEGAL} pat_kind_t;
  typedef struct packed {
    pat_kind_t  kind;
    logic [3:0] code;
  } pat_t;

  function automatic pat_t decode(input logic [6:0] p);
    pat_t r;
    r.kind = PAT_DIGIT;
    r.code = 4'h0;
    case (p)
      7'b0000001: r.code = 4'h0;
      7'b1001111: r.code = 4'h1;
      7'b0010010: r.code = 4'h2;
      7'b0000110: r.code = 4'h3;
      7'b1001100: r.code = 4'h4;
      7'b0100100: r.code = 4'h5;
      7'b0100000: r.code = 4'h6;
      7'b0001111: r.code = 4'h7;
      7'b0000000: r.code = 4'h8;
      7'b0000100: r.code = 4'h9;
`ifdef HEX_DECODE_EN
      7'b0001000: r.code = 4'hA;
      7'b1100000: r.code = 4'hB;
      7'b0110001: r.code = 4'hC;
      7'b1000010: r.code = 4'hD;
      7'b0110000: r.code = 4'hE;
      7'b0111000: r.code = 4'hF;
`endif
      7'b1111111: begin
        r.kind = PAT_BLANK;
        r.code = 4'hF;
      end
      default: r.kind = PAT_ILLEGAL;
    endcase
    return r;
  endfunction

  logic [3:0]       an_meta, s_an, ref_an;
  logic [6:0]       seg_meta, s_seg, ref_seg;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             load_ref, capture;
  logic             sel_valid;
  logic [1:0]       sel_idx;
  logic             same;
  pat_t             pat;
  logic [3:0]       mask, mask_set;
  logic [15:0]      digits_q;
  logic [3:0]       blank_q;
  logic             frame_done_q, pattern_err_q;
  logic [1:0]       err_digit_q;

  // A selection is only meaningful when exactly one anode is pulled low.
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (s_an)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  assign same     = (s_an == ref_an) && (s_seg == ref_seg);
  assign pat      = decode(s_seg);
  assign mask_set = mask | (4'b0001 << sel_idx);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    state_n  = state;
    cnt_n    = cnt;
    load_ref = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_n  = SETTLE;
          cnt_n    = CNT_W'(1);
          load_ref = 1'b1;
        end
      end
      SETTLE: begin
        if (!sel_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          cnt_n    = CNT_W'(1);
          load_ref = 1'b1;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          cnt_n   = CNT_W'(STABLE_CYCLES);
          capture = 1'b1;
          state_n = HELD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sel_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same) begin
          state_n  = SETTLE;
          cnt_n    = CNT_W'(1);
          load_ref = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      an_meta       <= 4'hF;
      s_an          <= 4'hF;
      seg_meta      <= 7'h7F;
      s_seg         <= 7'h7F;
      ref_an        <= 4'hF;
      ref_seg       <= 7'h7F;
      state         <= IDLE;
      cnt           <= '0;
      mask          <= 4'h0;
      digits_q      <= 16'h0000;
      blank_q       <= 4'h0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      err_digit_q   <= 2'd0;
    end else begin
      an_meta       <= bus.an;
      s_an          <= an_meta;
      seg_meta      <= bus.seg;
      s_seg         <= seg_meta;
      state         <= state_n;
      cnt           <= cnt_n;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      if (load_ref) begin
        ref_an  <= s_an;
        ref_seg <= s_seg;
      end
      if (capture) begin
        if (pat.kind == PAT_ILLEGAL) begin
          pattern_err_q <= 1'b1;
          err_digit_q   <= sel_idx;
        end else begin
          digits_q[{sel_idx, 2'b00} +: 4] <= pat.code;
          blank_q[sel_idx]                <= (pat.kind == PAT_BLANK);
          // The digit that completes the frame also restarts the mask.
          if (mask_set == 4'hF) begin
            frame_done_q <= 1'b1;
            mask         <= 4'h0;
          end else begin
            mask <= mask_set;
          end
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank       = blank_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.err_digit   = err_digit_q;

endmodule
